// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: chunk sizing, parameter
// legality and the per-stage control record.
package adder_pkg;

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Width-independent part of a stage record; the top adds the WIDTH-sized fields.
    typedef struct packed {
        logic valid;
        logic carry;
        logic msb_carry;
    } stage_ctl_t;

endpackage

// File: rtl/carry_chunk_adder.sv
// Combinational ripple adder for one chunk; also exposes the carry into the top bit
// so the final stage can form the signed-overflow flag.
module carry_chunk_adder #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             cin,
    output logic [Width-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [Width:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < Width; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[Width];
    assign cmsb = c[Width - 1];

endmodule

// File: rtl/pipelined_rca.sv
// Parametrised pipelined ripple-carry adder with valid/ready handshake; one chunk of the
// carry chain per register stage, all stages advancing together on a global enable.
module pipelined_rca
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned CW = chunk_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_rca: STAGES must be in 1..WIDTH and divide WIDTH");
    end

    // Sum fills in from the bottom while a/b carry the not-yet-consumed upper chunks.
    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];
    logic   en;

    assign out_valid = st_q[STAGES-1].ctl.valid;
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned Lo = k * CW;

        stage_t        prv;
        stage_t        nxt;
        logic [CW-1:0] chunk_sum;
        logic          chunk_cout;
        logic          chunk_cmsb;

        if (k == 0) begin : g_head
            always_comb begin
                prv           = '0;
                prv.ctl.valid = in_valid;
                prv.ctl.carry = Cin;
                prv.a         = A;
                prv.b         = B;
            end
        end else begin : g_body
            assign prv = st_q[k-1];
        end

        carry_chunk_adder #(
            .Width(CW)
        ) u_chunk (
            .a   (prv.a[Lo +: CW]),
            .b   (prv.b[Lo +: CW]),
            .cin (prv.ctl.carry),
            .sum (chunk_sum),
            .cout(chunk_cout),
            .cmsb(chunk_cmsb)
        );

        always_comb begin
            nxt               = prv;
            nxt.sum[Lo +: CW] = chunk_sum;
            nxt.ctl.carry     = chunk_cout;
            nxt.ctl.msb_carry = chunk_cmsb;
        end

        assign st_d[k] = nxt;
    end

    // Full reset of every stage keeps S/Cout/Ovf at zero until the first result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                st_q[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < STAGES; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

    assign S    = st_q[STAGES-1].sum;
    assign Cout = st_q[STAGES-1].ctl.carry;
    assign Ovf  = st_q[STAGES-1].ctl.msb_carry ^ st_q[STAGES-1].ctl.carry;

    // Operand copies in the last stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{st_q[STAGES-1].a, st_q[STAGES-1].b};

endmodule
